stdp_epoch_ctrl: RTL and testbench

STDP_EPOCH_CTRL -- requirements
Module: stdp_epoch_ctrl

---
 rtl/stdp_epoch_ctrl_pkg.sv | 15 +
 rtl/stdp_epoch_ctrl_sat_counter.sv | 26 ++
 rtl/stdp_epoch_ctrl.sv | 142 ++++++++++++++
 tb/tb_stdp_epoch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_epoch_ctrl_pkg.sv
// Shared types and defaults for the STDP epoch controller.
// Holds the FSM state encoding and default vector/counter widths.
package stdp_epoch_ctrl_pkg;

  localparam int N_IN_DEF  = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_REST,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/stdp_epoch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used to count neuron spikes during a run.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/stdp_epoch_ctrl.sv
// Epoch sequencer: presents a spike pattern to a neuron, lets it
// leak during rest, repeats for n epochs and counts output spikes.
module stdp_epoch_ctrl
  import stdp_epoch_ctrl_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [N_IN-1:0]  pattern,
  input  logic [CNT_W-1:0] present_len,
  input  logic [CNT_W-1:0] rest_len,
  input  logic [3:0]       n_epochs,
  input  logic             learn_en,
  input  logic             spike_in,
  output logic [N_IN-1:0]  spikes_out,
  output logic             learn,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] spike_count
);

  state_t           r_state;
  logic [N_IN-1:0]  r_pattern;
  logic [CNT_W-1:0] r_plen;
  logic [CNT_W-1:0] r_rlen;
  logic             r_learn_en;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_ep;
  logic             r_aborted;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [3:0]       w_ep_nx;
  logic             w_accept;
  logic             w_abort_nx;
  logic             w_inc;
  logic [CNT_W-1:0] w_plen_in;
  logic [3:0]       w_ep_in;

  // Zero lengths/epoch counts are promoted to one.
  assign w_plen_in = (present_len == '0) ? CNT_W'(1) : present_len;
  assign w_ep_in   = (n_epochs == 4'd0) ? 4'd1 : n_epochs;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ep_nx    = r_ep;
    w_accept   = 1'b0;
    w_abort_nx = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_accept   = 1'b1;
          w_state_nx = ST_PRESENT;
          w_cnt_nx   = w_plen_in - CNT_W'(1);
          w_ep_nx    = w_ep_in;
        end
      end
      ST_PRESENT: begin
        if (stop) begin
          w_state_nx = ST_IDLE;
          w_abort_nx = 1'b1;
        end else if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end else if (r_rlen != '0) begin
          w_state_nx = ST_REST;
          w_cnt_nx   = r_rlen - CNT_W'(1);
        end else begin
          w_ep_nx    = r_ep - 4'd1;
          w_cnt_nx   = r_plen - CNT_W'(1);
          w_state_nx = (r_ep == 4'd1) ? ST_FINISH : ST_PRESENT;
        end
      end
      ST_REST: begin
        if (stop) begin
          w_state_nx = ST_IDLE;
          w_abort_nx = 1'b1;
        end else if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end else begin
          w_ep_nx    = r_ep - 4'd1;
          w_cnt_nx   = r_plen - CNT_W'(1);
          w_state_nx = (r_ep == 4'd1) ? ST_FINISH : ST_PRESENT;
        end
      end
      ST_FINISH: begin
        w_state_nx = ST_IDLE;
        w_abort_nx = stop;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pattern  <= '0;
      r_plen     <= '0;
      r_rlen     <= '0;
      r_learn_en <= 1'b0;
      r_cnt      <= '0;
      r_ep       <= '0;
      r_aborted  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_ep      <= w_ep_nx;
      r_aborted <= w_abort_nx;
      if (w_accept) begin
        r_pattern  <= pattern;
        r_plen     <= w_plen_in;
        r_rlen     <= rest_len;
        r_learn_en <= learn_en;
      end
    end
  end

  // A stopping cycle does not count, so the abort value is retained.
  assign w_inc = spike_in && !stop &&
                 ((r_state == ST_PRESENT) || (r_state == ST_REST));

  sat_counter #(
    .W (CNT_W)
  ) u_spk_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_accept),
    .i_inc (w_inc),
    .o_cnt (spike_count)
  );

  assign spikes_out = (r_state == ST_PRESENT) ? r_pattern : '0;
  assign learn      = (r_state == ST_PRESENT) && r_learn_en;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FINISH);
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_stdp_epoch_ctrl.sv
// Self-checking bench for stdp_epoch_ctrl: table-driven runs with a
// per-cycle expected-output queue, plus abort and reset sequences.
module tb_stdp_epoch_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] pattern;
  logic [7:0] present_len;
  logic [7:0] rest_len;
  logic [3:0] n_epochs;
  logic       learn_en;
  logic       spike_in;
  logic [7:0] spikes_out;
  logic       learn;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] spike_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] plen;
    logic [7:0] rlen;
    logic [3:0] nep;
    logic       lrn;
    logic       spk;
    int         exp_cycles;
    logic [7:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] so;
    logic       ln;
    logic       bz;
    logic       dn;
  } exp_t;

  vec_t vecs[5];
  exp_t q[$];

  stdp_epoch_ctrl #(
    .N_IN  (8),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pattern     (pattern),
    .present_len (present_len),
    .rest_len    (rest_len),
    .n_epochs    (n_epochs),
    .learn_en    (learn_en),
    .spike_in    (spike_in),
    .spikes_out  (spikes_out),
    .learn       (learn),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .spike_count (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic push_model(input vec_t v);
    int ne;
    int np;
    exp_t e;
    ne = (v.nep == 0) ? 1 : int'(v.nep);
    np = (v.plen == 0) ? 1 : int'(v.plen);
    for (int k = 0; k < ne; k++) begin
      for (int i = 0; i < np; i++) begin
        e = '{v.pat, v.lrn, 1'b1, 1'b0};
        q.push_back(e);
      end
      for (int i = 0; i < int'(v.rlen); i++) begin
        e = '{8'h00, 1'b0, 1'b1, 1'b0};
        q.push_back(e);
      end
    end
    e = '{8'h00, 1'b0, 1'b1, 1'b1};
    q.push_back(e);
    e = '{8'h00, 1'b0, 1'b0, 1'b0};
    q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int   nb;
    logic seen;
    exp_t e;
    @(negedge clk);
    pattern     = v.pat;
    present_len = v.plen;
    rest_len    = v.rlen;
    n_epochs    = v.nep;
    learn_en    = v.lrn;
    spike_in    = v.spk;
    start       = 1'b1;
    push_model(v);
    nb   = 0;
    seen = 1'b0;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = q.pop_front();
      chk("spikes_out", spikes_out, e.so);
      chk("learn", learn, e.ln);
      chk("busy", busy, e.bz);
      chk("done", done, e.dn);
      chk("aborted", aborted, 0);
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        chk("cnt_at_done", spike_count, v.exp_cnt);
      end
    end
    chk("busy_len", nb, v.exp_cycles);
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("cnt_hold", spike_count, v.exp_cnt);
    spike_in = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'd3,   8'd2, 4'd1, 1'b1, 1'b0, 6,   8'd0};
    vecs[1] = '{8'h3C, 8'd0,   8'd0, 4'd0, 1'b1, 1'b0, 2,   8'd0};
    vecs[2] = '{8'h5A, 8'd2,   8'd1, 4'd3, 1'b0, 1'b1, 10,  8'd9};
    vecs[3] = '{8'hFF, 8'd255, 8'd0, 4'd2, 1'b1, 1'b1, 511, 8'd255};
    vecs[4] = '{8'h81, 8'd1,   8'd3, 4'd2, 1'b1, 1'b1, 9,   8'd8};

    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    pattern = '0;
    present_len = '0;
    rest_len = '0;
    n_epochs = '0;
    learn_en = 1'b0;
    spike_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_spikes", spikes_out, 0);
    chk("rst_learn", learn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", aborted, 0);
    chk("rst_cnt", spike_count, 0);

    // start and stop together in IDLE is ignored
    pattern = 8'hEE; present_len = 8'd2; n_epochs = 4'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 0);
    chk("start_stop_so", spikes_out, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // abort in second REST cycle; mid-run start ignored
    @(negedge clk);
    pattern = 8'hF0; present_len = 8'd2; rest_len = 8'd3;
    n_epochs = 4'd2; learn_en = 1'b0; spike_in = 1'b1; start = 1'b1;
    @(negedge clk);
    pattern = 8'h11; present_len = 8'd9;
    chk("ab_p1_so", spikes_out, 8'hF0);
    chk("ab_p1_busy", busy, 1);
    @(negedge clk);
    start = 1'b0;
    chk("ab_p2_so", spikes_out, 8'hF0);
    @(negedge clk);
    chk("ab_r1_so", spikes_out, 0);
    chk("ab_r1_busy", busy, 1);
    @(negedge clk);
    chk("ab_r2_busy", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_pulse", aborted, 1);
    chk("ab_done", done, 0);
    chk("ab_cnt", spike_count, 3);
    @(negedge clk);
    chk("ab_pulse_end", aborted, 0);
    chk("ab_done2", done, 0);
    chk("ab_cnt_hold", spike_count, 3);
    spike_in = 1'b0;

    // asynchronous reset mid-PRESENT
    @(negedge clk);
    pattern = 8'h0F; present_len = 8'd5; rest_len = 8'd0;
    n_epochs = 4'd1; learn_en = 1'b1; spike_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rp_so", spikes_out, 8'h0F);
    chk("rp_learn", learn, 1);
    @(negedge clk);
    chk("rp_cnt", spike_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_spikes", spikes_out, 0);
    chk("ar_learn", learn, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_abort", aborted, 0);
    chk("ar_cnt", spike_count, 0);
    @(negedge clk);
    reset = 1'b0;
    spike_in = 1'b0;
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
